mc_ctrl_fsm: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 73 +++++++
 rtl/mc_alu_dec.sv | 43 ++++
 rtl/mc_ctrl_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: state codes,
// opcode/funct values, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_IF    = 4'd0;
   localparam state_t S_ID    = 4'd1;
   localparam state_t S_EX_R  = 4'd2;
   localparam state_t S_WB_R  = 4'd3;
   localparam state_t S_EX_I  = 4'd4;
   localparam state_t S_WB_I  = 4'd5;
   localparam state_t S_ADDR  = 4'd6;
   localparam state_t S_MRD   = 4'd7;
   localparam state_t S_WB_LW = 4'd8;
   localparam state_t S_MWR   = 4'd9;
   localparam state_t S_BR    = 4'd10;
   localparam state_t S_JMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_LUI  = 4'd8;
   localparam logic [3:0] ALU_ADDU = 4'd9;
   localparam logic [3:0] ALU_SUBU = 4'd10;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [1:0] SRCB_REG     = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   // Arithmetic, compare and address immediates are sign-extended; logical ones are not.
   function automatic logic ext_signed(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
             (op == OP_LW)   || (op == OP_SW)    ||
             (op == OP_BEQ)  || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder shared by the R-type and I-type execute states.
// legal is low when op/funct name no ALU operation this decoder knows.
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl,
   output logic       legal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      legal    = 1'b1;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_ADDU: alu_ctrl = ALU_ADDU;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_SUBU: alu_ctrl = ALU_SUBU;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_XOR:  alu_ctrl = ALU_XOR;
            FN_NOR:  alu_ctrl = ALU_NOR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_SLTU: alu_ctrl = ALU_SLTU;
            default: legal    = 1'b0;
         endcase
      end else begin
         case (op)
            OP_ADDI:  alu_ctrl = ALU_ADD;
            OP_ADDIU: alu_ctrl = ALU_ADDU;
            OP_SLTI:  alu_ctrl = ALU_SLT;
            OP_ANDI:  alu_ctrl = ALU_AND;
            OP_ORI:   alu_ctrl = ALU_OR;
            OP_XORI:  alu_ctrl = ALU_XOR;
            OP_LUI:   alu_ctrl = ALU_LUI;
            default:  legal    = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: sequences IF/ID/EX/MEM/WB and drives datapath controls.
// Optional CTRL_PERF_EN adds instr_retired and cycle_count counters.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter logic [3:0] MEM_WAIT_MAX = 4'd15
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_ctrl,
   output logic        ext_sign,
   output logic        illegal_instr,
   output logic        mem_timeout
`ifdef CTRL_PERF_EN
   ,
   output logic [31:0] instr_retired,
   output logic [31:0] cycle_count
`endif
);

   state_t     state, state_nx;
   logic [3:0] wcnt;
   logic [3:0] dec_alu;
   logic       dec_legal;
   logic       wait_st, timeout, known_op, id_illegal;

   mc_alu_dec u_alu_dec (
      .op       (op),
      .funct    (funct),
      .alu_ctrl (dec_alu),
      .legal    (dec_legal)
   );

   assign wait_st  = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
   assign timeout  = wait_st && !mem_ready && (wcnt == MEM_WAIT_MAX);
   assign known_op = (op == OP_RTYPE) ? dec_legal
                   : (dec_legal || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J));
   assign id_illegal = (state == S_ID) && !known_op;

   always_comb begin
      state_nx = state;
      case (state)
         S_IF:    if (!timeout && mem_ready) state_nx = S_ID;
         S_ID: begin
            if (id_illegal)                          state_nx = S_IF;
            else if (op == OP_RTYPE)                 state_nx = S_EX_R;
            else if ((op == OP_LW) || (op == OP_SW)) state_nx = S_ADDR;
            else if ((op == OP_BEQ) || (op == OP_BNE)) state_nx = S_BR;
            else if (op == OP_J)                     state_nx = S_JMP;
            else                                     state_nx = S_EX_I;
         end
         S_EX_R:  state_nx = S_WB_R;
         S_EX_I:  state_nx = S_WB_I;
         S_ADDR:  state_nx = (op == OP_LW) ? S_MRD : S_MWR;
         S_MRD: begin
            if (timeout)        state_nx = S_IF;
            else if (mem_ready) state_nx = S_WB_LW;
         end
         S_MWR:   if (timeout || mem_ready) state_nx = S_IF;
         default: state_nx = S_IF;
      endcase
   end

   // Wait counter restarts whenever a memory wait ends, either by completion or by timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IF;
         wcnt     <= 4'd0;
         ext_sign <= 1'b0;
      end else begin
         state <= state_nx;
         if (!wait_st || mem_ready || timeout) wcnt <= 4'd0;
         else                                  wcnt <= wcnt + 4'd1;
         if (state == S_ID) ext_sign <= ext_signed(op);
      end
   end

   // Outputs are forced low while reset is held so no strobe escapes during an abort.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PC_SRC_ALU;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_ctrl      = ALU_ADD;
      illegal_instr = 1'b0;
      mem_timeout   = 1'b0;
      if (rst_n) begin
         case (state)
            S_IF: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_ID:    alu_src_b = SRCB_IMM_SH2;
            S_EX_R: begin
               alu_src_a = 1'b1;
               alu_ctrl  = dec_alu;
            end
            S_WB_R: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_EX_I: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_ctrl  = dec_alu;
            end
            S_WB_I:  reg_write = 1'b1;
            S_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_MRD: begin
               i_or_d   = 1'b1;
               mem_read = 1'b1;
            end
            S_WB_LW: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MWR: begin
               i_or_d    = 1'b1;
               mem_write = 1'b1;
            end
            S_BR: begin
               // pc_write_cond carries the already-qualified condition: zero for beq, !zero for bne.
               alu_src_a     = 1'b1;
               alu_ctrl      = ALU_SUB;
               pc_src        = PC_SRC_ALUOUT;
               pc_write_cond = (op == OP_BNE) ? !zero : zero;
            end
            S_JMP: begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_JUMP;
            end
            default: ;
         endcase
         illegal_instr = id_illegal;
         mem_timeout   = timeout;
      end
   end

`ifdef CTRL_PERF_EN
   logic retire;

   assign retire = (state != S_IF) && (state_nx == S_IF) && !timeout && !id_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_retired <= 32'd0;
         cycle_count   <= 32'd0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (retire) instr_retired <= instr_retired + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized self-checking bench for mc_ctrl_fsm; each instruction is walked through
// its expected step sequence by a procedural reference model.
module tb_mc_ctrl_fsm;

   localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_BNE = 6, C_J = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
   logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_sign, illegal_instr, mem_timeout;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_ctrl;
`ifdef CTRL_PERF_EN
   logic [31:0] instr_retired, cycle_count;
   logic [31:0] cc0;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   int   step_n = 0;
   int   s0 = 0;
   int   retired_m = 0;
   logic exp_ext = 1'b0;
   bit   ld = 1'b0;
   logic [5:0] ld_op = 6'd0, ld_funct = 6'd0;
   logic       ld_zero = 1'b0;
   logic [19:0] obs;

   mc_ctrl_fsm dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op            (op),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .ir_write      (ir_write),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_ctrl      (alu_ctrl),
      .ext_sign      (ext_sign),
      .illegal_instr (illegal_instr),
      .mem_timeout   (mem_timeout)
`ifdef CTRL_PERF_EN
      ,
      .instr_retired (instr_retired),
      .cycle_count   (cycle_count)
`endif
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
                 illegal_instr, mem_timeout};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [19:0] mk(input bit pcw, pcwc, input bit [1:0] pcs,
                                      input bit irw, iord, mrd, mwr, rw, rdst, m2r, asa,
                                      input bit [1:0] asb, input bit [3:0] actl,
                                      input bit ill, to);
      return {pcw, pcwc, pcs, irw, iord, mrd, mwr, rw, rdst, m2r, asa, asb, actl, ill, to};
   endfunction

   function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'h00: return (f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B}) ? C_R : C_ILL;
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return C_I;
         6'h23: return C_LW;
         6'h2B: return C_SW;
         6'h04: return C_BEQ;
         6'h05: return C_BNE;
         6'h02: return C_J;
         default: return C_ILL;
      endcase
   endfunction

   // ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 SLTU=7 LUI=8 ADDU=9 SUBU=10
   function automatic logic [3:0] alu_of(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) begin
         case (f)
            6'h20: return 4'd0;  6'h21: return 4'd9;  6'h22: return 4'd1;  6'h23: return 4'd10;
            6'h24: return 4'd2;  6'h25: return 4'd3;  6'h26: return 4'd4;  6'h27: return 4'd5;
            6'h2A: return 4'd6;  6'h2B: return 4'd7;
            default: return 4'd0;
         endcase
      end
      case (o)
         6'h09: return 4'd9;  6'h0A: return 4'd6;  6'h0C: return 4'd2;
         6'h0D: return 4'd3;  6'h0E: return 4'd4;  6'h0F: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic sext_of(input logic [5:0] o);
      return o inside {6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05};
   endfunction

   task automatic step(input string tag, input logic rdy, input logic [19:0] exp);
      @(negedge clk);
      if (ld) begin
         op = ld_op; funct = ld_funct; zero = ld_zero; ld = 1'b0;
      end
      mem_ready = rdy;
      #1;
      step_n++;
      chk(tag, 32'(obs), 32'(exp));
      chk({tag, "_ext"}, 32'(ext_sign), 32'(exp_ext));
   endtask

   // kind 0 = fetch, 1 = load read, 2 = store write; a wait of 16 or more hits the limit of 15.
   task automatic mem_phase(input int kind, input int waits, output bit aborted);
      logic [19:0] vw, vd;
      string nm;
      int w, n;
      w = waits; n = 0; aborted = 1'b0;
      case (kind)
         0: begin
            nm = "IF";
            vw = mk(0,0,2'd0,0,0,1,0,0,0,0,0,2'd1,4'd0,0,0);
            vd = mk(1,0,2'd0,1,0,1,0,0,0,0,0,2'd1,4'd0,0,0);
         end
         1: begin
            nm = "MRD";
            vw = mk(0,0,2'd0,0,1,1,0,0,0,0,0,2'd0,4'd0,0,0);
            vd = vw;
         end
         default: begin
            nm = "MWR";
            vw = mk(0,0,2'd0,0,1,0,1,0,0,0,0,2'd0,4'd0,0,0);
            vd = vw;
         end
      endcase
      forever begin
         if (w == 0) begin
            step({nm, "_done"}, 1'b1, vd);
            break;
         end
         if (n == 15) begin
            step({nm, "_timeout"}, 1'b0, vw | 20'h1);
            w--; n = 0;
            if (kind != 0) begin
               aborted = 1'b1;
               break;
            end
         end else begin
            step({nm, "_wait"}, 1'b0, vw);
            w--; n++;
         end
      end
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int wif, input int wmem);
      int c;
      logic [3:0] a;
      bit ab;
      bit pcwc;
      c = cls_of(o, f);
      a = alu_of(o, f);
      ld = 1'b1; ld_op = o; ld_funct = f; ld_zero = z;
      mem_phase(0, wif, ab);
      step("ID", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,0,0,0,0,2'd3,4'd0,c == C_ILL,0));
      exp_ext = sext_of(o);
      case (c)
         C_R: begin
            step("EX_R", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd0,a,0,0));
            step("WB_R", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,1,1,0,0,2'd0,4'd0,0,0));
            retired_m++;
         end
         C_I: begin
            step("EX_I", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,a,0,0));
            step("WB_I", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,1,0,0,0,2'd0,4'd0,0,0));
            retired_m++;
         end
         C_LW, C_SW: begin
            step("ADDR", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,4'd0,0,0));
            mem_phase((c == C_LW) ? 1 : 2, wmem, ab);
            if (!ab) begin
               if (c == C_LW)
                  step("WB_LW", 1'($urandom_range(1, 0)), mk(0,0,2'd0,0,0,0,0,1,0,1,0,2'd0,4'd0,0,0));
               retired_m++;
            end
         end
         C_BEQ, C_BNE: begin
            pcwc = (c == C_BEQ) ? z : !z;
            step("BR", 1'($urandom_range(1, 0)), mk(0,pcwc,2'd1,0,0,0,0,0,0,0,1,2'd0,4'd1,0,0));
            retired_m++;
         end
         C_J: begin
            step("JMP", 1'($urandom_range(1, 0)), mk(1,0,2'd2,0,0,0,0,0,0,0,0,2'd0,4'd0,0,0));
            retired_m++;
         end
         default: ;
      endcase
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] opool [16];
      logic [5:0] fpool [10];
      logic [5:0] o, f;
      bit ab;
      opool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
      fpool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", 32'(obs), 32'd0);
      chk("reset_ext", 32'(ext_sign), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("after_reset_if", 32'(obs), 32'(mk(0,0,2'd0,0,0,1,0,0,0,0,0,2'd1,4'd0,0,0)));

      // directed cases
      run_instr(6'h08, 6'h3F, 1'b0, 0, 0);   // addi
      run_instr(6'h0D, 6'h00, 1'b0, 0, 0);   // ori
      run_instr(6'h23, 6'h00, 1'b0, 1, 3);   // lw, 3 wait cycles in MRD
      run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
      run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
      run_instr(6'h04, 6'h00, 1'b0, 0, 0);
      run_instr(6'h05, 6'h00, 1'b0, 0, 0);
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal opcode
      run_instr(6'h00, 6'h00, 1'b0, 0, 0);   // illegal funct
      run_instr(6'h08, 6'h00, 1'b0, 16, 0);  // fetch timeout then retry
      run_instr(6'h2B, 6'h00, 1'b0, 0, 16);  // store timeout abort
      run_instr(6'h2B, 6'h00, 1'b0, 0, 0);
      run_instr(6'h00, 6'h27, 1'b0, 2, 0);   // nor
      run_instr(6'h0F, 6'h00, 1'b0, 0, 0);   // lui
      run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j

      // asynchronous reset during a store wait
      ld = 1'b1; ld_op = 6'h2B; ld_funct = 6'h00; ld_zero = 1'b0;
      mem_phase(0, 0, ab);
      step("ID", 1'b0, mk(0,0,2'd0,0,0,0,0,0,0,0,0,2'd3,4'd0,0,0));
      exp_ext = 1'b1;
      step("ADDR", 1'b0, mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,4'd0,0,0));
      step("MWR_wait", 1'b0, mk(0,0,2'd0,0,1,0,1,0,0,0,0,2'd0,4'd0,0,0));
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mwr_outputs", 32'(obs), 32'd0);
      chk("rst_mwr_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mwr_ext", 32'(ext_sign), 32'd0);
      rst_n = 1'b1;
      exp_ext = 1'b0;
      retired_m = 0;
      #1;
      chk("rst_mwr_release_if", 32'(obs), 32'(mk(0,0,2'd0,0,0,1,0,0,0,0,0,2'd1,4'd0,0,0)));

      run_instr(6'h08, 6'h00, 1'b0, 0, 0);
      run_instr(6'h08, 6'h00, 1'b0, 0, 0);
      run_instr(6'h08, 6'h00, 1'b0, 0, 0);
`ifdef CTRL_PERF_EN
      cc0 = cycle_count;
`endif
      s0 = step_n;
      @(posedge clk);
      #1;
`ifdef CTRL_PERF_EN
      chk("perf_retired_3addi", instr_retired, 32'd3);
`endif

      // randomized instruction stream
      for (int i = 0; i < 200; i++) begin
         o = ($urandom_range(7, 0) == 0) ? 6'($urandom) : opool[$urandom_range(15, 0)];
         f = ($urandom_range(3, 0) == 0) ? 6'($urandom) : fpool[$urandom_range(9, 0)];
         run_instr(o, f, 1'($urandom_range(1, 0)),
                   ($urandom_range(9, 0) == 0) ? int'($urandom_range(33, 15)) : int'($urandom_range(3, 0)),
                   ($urandom_range(9, 0) == 0) ? int'($urandom_range(20, 14)) : int'($urandom_range(4, 0)));
      end
      @(posedge clk);
      #1;
`ifdef CTRL_PERF_EN
      chk("perf_retired_total", instr_retired, 32'(retired_m));
      chk("perf_cycles", cycle_count - cc0, 32'(step_n - s0 + 1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
